// File: rtl/kyber_coef_pkg.sv
// Shared types for the Baby-Kyber coefficient datapath.
//   Q / COEF_W : default modulus and coefficient width
//   coef_t     : one reduced coefficient
//   coef_mode_t: field decode mode (plain bits or centred binomial)
//   state_t    : stream decoder FSM state
package kyber_coef_pkg;
  localparam int Q      = 17;
  localparam int COEF_W = $clog2(Q);

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic {MODE_RAW = 1'b0, MODE_CBD = 1'b1} coef_mode_t;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;
endpackage

// File: rtl/coef_stream_decoder_cbd.sv
// cbd_sample: combinational centred-binomial sampler.
//   field_i : 2*ETA-bit field, low ETA bits count positive, high ETA negative
//   coef_o  : (popcount(low) - popcount(high)) mod Q, always in [0, Q-1]
module cbd_sample #(
  parameter int ETA = 2,
  parameter int Q   = 17,
  localparam int CW = $clog2(Q)
) (
  input  logic [2*ETA-1:0] field_i,
  output logic [CW-1:0]    coef_o
);
  // One spare bit so the difference can go negative without wrapping.
  logic signed [CW:0] diff;

  always_comb begin
    diff = '0;
    for (int i = 0; i < ETA; i++) begin
      diff = diff + (CW+1)'(field_i[i]);
      diff = diff - (CW+1)'(field_i[ETA+i]);
    end
    // |diff| <= ETA < Q, so a single conditional add of Q fully reduces it.
    coef_o = diff[CW] ? CW'(diff + (CW+1)'(Q)) : CW'(diff);
  end
endmodule

// File: rtl/coef_stream_decoder.sv
// coef_stream_decoder: splits packed IN_W-bit words into one coefficient per
// output handshake, tracking index within an N-coefficient polynomial.
//   clk, rst            : clock, async active-high reset
//   mode_i              : 0=RAW (D-bit fields), 1=CBD (2*ETA-bit fields);
//                         latched only on the first word of a polynomial
//   in_data/valid/ready : packed word input, fields taken LSB first
//   coef_o/idx/last     : decoded coefficient, its index, last-of-poly flag
//   coef_valid/ready    : coefficient output handshake
//   busy                : polynomial in progress
// IN_W must be a multiple of D and of 2*ETA; D <= $clog2(Q).
module coef_stream_decoder #(
  parameter int IN_W = 32,
  parameter int D    = 2,
  parameter int ETA  = 2,
  parameter int N    = 4,
  parameter int Q    = 17,
  localparam int COEF_W = $clog2(Q),
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_i,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [COEF_W-1:0] coef_o,
  output logic [IDX_W-1:0]  coef_idx,
  output logic              coef_last,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              busy
);
  import kyber_coef_pkg::*;

  localparam int CF  = 2*ETA;
  localparam int SHW = $clog2(IN_W);

  state_t            state_q, state_d;
  coef_mode_t        mode_q, mode_d;
  logic [IN_W-1:0]   word_q, word_d;
  logic [SHW-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  int                fld_w;
  logic [SHW-1:0]    ptr_last, sh;
  logic [COEF_W-1:0] raw_c, cbd_c;
  logic              cnt_last, end_word, fire, accept;

  always_comb begin
    if (mode_q == MODE_CBD) begin
      fld_w    = CF;
      ptr_last = SHW'(IN_W/CF - 1);
    end else begin
      fld_w    = D;
      ptr_last = SHW'(IN_W/D - 1);
    end
  end

  assign sh = SHW'(int'(ptr_q) * fld_w);

  // Both decoders look at the same bit offset; only the one matching
  // mode_q is selected, so an overhanging RAW select in CBD mode is unused.
  assign raw_c = COEF_W'(word_q[sh +: D]);

  cbd_sample #(.ETA(ETA), .Q(Q)) u_cbd (
    .field_i (word_q[sh +: CF]),
    .coef_o  (cbd_c)
  );

  assign cnt_last   = (cnt_q == IDX_W'(N-1));
  // Reaching coefficient N-1 ends the word early; leftover bits are dropped.
  assign end_word   = cnt_last || (ptr_q == ptr_last);
  assign coef_valid = (state_q == EMIT);
  assign fire       = coef_valid && coef_ready;
  // Skip-bubble: take the next word in the cycle the last field drains.
  assign in_ready   = (state_q == IDLE) || (fire && end_word);
  assign accept     = in_valid && in_ready;

  assign coef_o    = coef_valid ? ((mode_q == MODE_CBD) ? cbd_c : raw_c) : '0;
  assign coef_idx  = cnt_q;
  assign coef_last = coef_valid && cnt_last;
  assign busy      = (cnt_q != '0) || coef_valid;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    word_d  = word_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (fire) begin
      ptr_d = ptr_q + 1'b1;
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
      if (end_word) state_d = IDLE;
    end
    if (accept) begin
      word_d  = in_data;
      ptr_d   = '0;
      state_d = EMIT;
      // Mode is fixed for the whole polynomial: only a fresh one relatches.
      if (cnt_d == '0) mode_d = coef_mode_t'(mode_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_RAW;
      word_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_coef_stream_decoder.sv
module tb_coef_stream_decoder;
  localparam int ETA = 2;

  typedef struct {
    int coef;
    int idx;
    bit last;
  } exp_t;

  logic clk;
  logic rst, rst8;
  logic        mode_i[2], in_valid[2], in_ready[2];
  logic        coef_last[2], coef_valid[2], coef_ready[2], busy[2];
  logic [31:0] in_data[2];
  logic [4:0]  coef_a;
  logic [11:0] coef_b;
  logic [1:0]  idx_a;
  logic [2:0]  idx_b;

  int   tests = 0, fails = 0;
  exp_t q0[$], q1[$];
  int   pcnt[2], pmode[2];
  bit   rnd_on;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  coef_stream_decoder #(.IN_W(32), .D(2), .ETA(ETA), .N(4), .Q(17)) u_dut (
    .clk(clk), .rst(rst), .mode_i(mode_i[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .coef_o(coef_a),
    .coef_idx(idx_a), .coef_last(coef_last[0]), .coef_valid(coef_valid[0]),
    .coef_ready(coef_ready[0]), .busy(busy[0])
  );

  coef_stream_decoder #(.IN_W(32), .D(8), .ETA(ETA), .N(8), .Q(3329)) u_dut8 (
    .clk(clk), .rst(rst8), .mode_i(mode_i[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .coef_o(coef_b),
    .coef_idx(idx_b), .coef_last(coef_last[1]), .coef_valid(coef_valid[1]),
    .coef_ready(coef_ready[1]), .busy(busy[1])
  );

  function automatic int dpar(int s); return (s != 0) ? 8 : 2; endfunction
  function automatic int npar(int s); return (s != 0) ? 8 : 4; endfunction
  function automatic int qpar(int s); return (s != 0) ? 3329 : 17; endfunction
  function automatic int get_coef(int s); return (s != 0) ? int'(coef_b) : int'(coef_a); endfunction
  function automatic int get_idx(int s); return (s != 0) ? int'(idx_b) : int'(idx_a); endfunction

  // Reference: k-th field of word w, decoded by the mode rules.
  function automatic int model_coef(logic [31:0] w, int m, int k, int d, int q);
    int f, fld, a, b;
    f   = (m != 0) ? 2*ETA : d;
    fld = int'((w >> (k*f)) & ((32'd1 << f) - 32'd1));
    if (m == 0) return fld;
    a = $countones(fld % (1 << ETA));
    b = $countones(fld / (1 << ETA));
    return ((a - b) % q + q) % q;
  endfunction

  task automatic chk(string nm, int got, int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got %0d required %0d", nm, got, req);
    end
  endtask

  // Present a word, wait for the handshake, then queue what it must produce.
  task automatic send(int s, logic [31:0] w, bit m);
    bit ok;
    int f, fpw;
    exp_t e;
    ok = 0;
    in_data[s] = w; mode_i[s] = m; in_valid[s] = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (in_ready[s]) ok = 1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout dut%0d got no in_ready required in_ready=1", s);
      in_valid[s] = 1'b0;
      return;
    end
    if (pcnt[s] == 0) pmode[s] = int'(m);
    f   = (pmode[s] != 0) ? 2*ETA : dpar(s);
    fpw = 32 / f;
    for (int k = 0; k < fpw; k++) begin
      e.coef = model_coef(w, pmode[s], k, dpar(s), qpar(s));
      e.idx  = pcnt[s];
      e.last = (pcnt[s] == npar(s) - 1);
      if (s == 0) q0.push_back(e); else q1.push_back(e);
      pcnt[s]++;
      if (pcnt[s] == npar(s)) begin pcnt[s] = 0; break; end
    end
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && (q0.size() + q1.size()) != 0; c++) @(negedge clk);
    chk("drain_pending", q0.size() + q1.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: every output handshake pops and checks one expected coefficient.
  exp_t me;
  bit   mhave;
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (coef_valid[s] && coef_ready[s]) begin
        mhave = 0;
        if (s == 0 && q0.size() > 0) begin me = q0.pop_front(); mhave = 1; end
        if (s == 1 && q1.size() > 0) begin me = q1.pop_front(); mhave = 1; end
        tests++;
        if (!mhave) begin
          fails++;
          $display("FAIL unexpected_coef dut%0d got coef=%0d idx=%0d required none",
                   s, get_coef(s), get_idx(s));
        end else if (get_coef(s) != me.coef || get_idx(s) != me.idx ||
                     coef_last[s] != me.last) begin
          fails++;
          $display("FAIL coef_stream dut%0d got coef=%0d idx=%0d last=%0d required coef=%0d idx=%0d last=%0d",
                   s, get_coef(s), get_idx(s), coef_last[s], me.coef, me.idx, me.last);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int run;
    rst = 1'b1; rst8 = 1'b1; rnd_on = 0;
    for (int s = 0; s < 2; s++) begin
      mode_i[s] = 0; in_valid[s] = 0; in_data[s] = '0; coef_ready[s] = 1;
      pcnt[s] = 0; pmode[s] = 0;
    end
    in_valid[0] = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready[0]), 1);
    chk("rst_coef_valid", int'(coef_valid[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_idx", get_idx(0), 0);
    @(negedge clk);
    rst = 1'b0; rst8 = 1'b0; in_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_emit", int'(coef_valid[0]), 0);
    end
    @(posedge clk); #1;

    // RAW 0xE4 -> 0,1,2,3; first coefficient one cycle after accept.
    send(0, 32'hFFFF_FFE4, 0);
    chk("first_latency", int'(coef_valid[0]), 1);
    chk("busy_emit", int'(busy[0]), 1);
    drain();
    @(negedge clk);
    chk("post_poly_valid", int'(coef_valid[0]), 0);
    chk("post_poly_busy", int'(busy[0]), 0);
    @(posedge clk); #1;

    // CBD 0xF5C3 -> 2,15,0,0.
    send(0, 32'h0000_F5C3, 1);
    drain();

    // Backpressure at idx 1.
    send(0, 32'h0000_001B, 0);
    @(posedge clk); #1;
    coef_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", int'(coef_valid[0]), 1);
      chk("stall_idx", get_idx(0), 1);
      chk("stall_coef", get_coef(0), model_coef(32'h1B, 0, 1, 2, 17));
      chk("stall_in_ready", int'(in_ready[0]), 0);
    end
    @(posedge clk); #1;
    coef_ready[0] = 1'b1;
    drain();

    // Back-to-back: RAW then CBD with no bubble.
    run = 0;
    fork
      begin
        send(0, 32'h0000_00E4, 0);
        send(0, 32'h0000_5C3C, 1);
      end
      begin
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
          @(negedge clk);
          if (coef_valid[0]) ok = 1;
        end
        if (ok) begin
          run = 1;
          for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (!coef_valid[0]) break;
            run++;
          end
        end
      end
    join
    chk("b2b_run", run, 8);
    drain();

    // Randomized stream with random backpressure.
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(posedge clk); #1;
        coef_ready[0] = ($urandom_range(0, 3) != 0);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(0, $urandom, 1'($urandom_range(0, 1)));
        end
        rnd_on = 0;
      end
    join
    @(posedge clk); #1;
    coef_ready[0] = 1'b1;
    drain();

    // Multi-word polynomial (D=8, N=8); mode flip mid-poly is ignored.
    send(1, 32'h4433_2211, 0);
    drain();
    chk("busy_between_words", int'(busy[1]), 1);
    send(1, 32'hC3F5_0A99, 1);
    drain();

    // Reset at idx 5 drops the partial polynomial.
    send(1, 32'h0102_0304, 0);
    send(1, 32'h0506_0708, 0);
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (coef_valid[1] && idx_b == 3'd5) ok = 1;
    end
    chk("reach_idx5", int'(ok), 1);
    #2 rst8 = 1'b1;
    #1;
    chk("rst_async_valid", int'(coef_valid[1]), 0);
    chk("rst_async_busy", int'(busy[1]), 0);
    chk("rst_async_idx", get_idx(1), 0);
    q1.delete();
    pcnt[1] = 0;
    @(negedge clk); #2 rst8 = 1'b0;
    @(posedge clk); #1;
    send(1, 32'hDEAD_BEEF, 0);
    chk("restart_idx", get_idx(1), 0);
    send(1, 32'h1234_5678, 0);
    drain();

    // Random words on the wide instance, including CBD wrap mod 3329.
    for (int i = 0; i < 12; i++) send(1, $urandom, 1'($urandom_range(0, 1)));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/coef_stream_decoder.md
Name: coef_stream_decoder

Overview:
- Streaming successor to the fixed 8-bit-to-four-2-bit coefficient splitter.
- Accepts packed IN_W-bit words over a valid/ready handshake and emits one polynomial coefficient per handshake.
- Two decode modes:
  - RAW: plain D-bit fields.
  - CBD: centred-binomial sample mod Q from 2*ETA-bit fields.
- Sits between the input/sampler buffer and the Baby-Kyber NTT/poly-arithmetic stage. Tracks coefficient index and polynomial boundaries.

Parameters:
- IN_W, 32, input word width; must be a multiple of D and of 2*ETA.
- D, 2, RAW field width; D <= COEF_W.
- ETA, 2, CBD parameter; CBD field width is 2*ETA.
- N, 4, coefficients per polynomial.
- Q, 17, modulus; COEF_W = $clog2(Q), derived localparam.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- mode_i  in  1  0=RAW, 1=CBD; sampled on the first word of each polynomial.
- in_data  in  IN_W  packed word, LSB-first fields.
- in_valid  in  1  word valid.
- in_ready  out  1  word accepted when in_valid&&in_ready.
- coef_o  out  COEF_W  decoded coefficient.
- coef_idx  out  $clog2(N)  index within polynomial.
- coef_last  out  1  high with coefficient N-1.
- coef_valid  out  1  coefficient valid.
- coef_ready  in  1  downstream ready.
- busy  out  1  polynomial in progress (coefficient count != 0, or in EMIT).

Behaviour:
- Reset values, asynchronous and immediate: state=IDLE, coef_valid=0, coef_o=0, coef_idx=0, coef_last=0, busy=0, mode register=RAW, word register=0. in_ready=1 after reset.
- Field width F = mode ? 2*ETA : D. Fields per word FPW = IN_W/F.
- FSM IDLE:
  - in_ready=1.
  - On accept: load word, field ptr=0. If coef count==0, latch mode_i. Go to EMIT.
- FSM EMIT:
  - coef_valid=1; coef_o is decoded from field ptr.
  - On coef_valid&&coef_ready: ptr++, coef count++.
  - If count was N-1: count wraps to 0, go to IDLE. Remaining bits of the word are discarded.
  - Else if ptr was FPW-1: go to IDLE. Polynomial continues in the next word.
- Skip-bubble: in_ready is also 1 in EMIT when coef_ready is high and the current field is the last one for this word. A word accepted in that cycle goes straight to EMIT with no idle cycle. This is the only comb path, ready->ready.
- Latency: word accepted at cycle t -> first coef_valid at t+1. Sustained rate is one coefficient per cycle.
- Outputs are held stable while coef_valid && !coef_ready.
- RAW decode: coef_o = zero-extended field. No reduction.
- CBD decode:
  - a = popcount(field[ETA-1:0]), b = popcount(field[2ETA-1:ETA]).
  - coef_o = a-b if a>=b, else Q-(b-a).
  - Computed in COEF_W+1 bits signed; result always in [0,Q-1].
- Polynomial spanning words (N*F > IN_W): count persists across words, and mode stays latched until the polynomial completes.
- mode_i changes mid-polynomial are ignored.
- in_valid with in_ready=0: the word is not consumed, and the source must hold it.
- Reset mid-polynomial: all state is cleared, the partial polynomial is dropped, and the next accepted word starts at idx 0.

Decomposition:
- Package kyber_coef_pkg:
  - Q and COEF_W localparams.
  - typedef enum {MODE_RAW, MODE_CBD} coef_mode_t.
  - typedef coef_t (logic [COEF_W-1:0]).
  - FSM state enum {IDLE, EMIT}.
- Sub-module cbd_sample (combinational, params ETA and Q): field in, coef_t out. Reusable by the sampler.

Test Plan:
- Reset: assert rst with in_valid=1 -> in_ready=1 and coef_valid=0 immediately. After release, nothing is emitted until a handshake.
- RAW, D=2: in_data=32'h0000_00E4 -> coefs 0,1,2,3 with idx 0..3 on cycles t+1..t+4, coef_last on idx 3; upper 24 bits discarded.
- CBD, ETA=2: in_data=32'h0000_F5C3 -> coefs 2,15,0,0 (0011->2, 1100->Q-2=15, 0101->0, 1111->0).
- Backpressure: coef_ready=0 for 5 cycles at idx 1 -> coef_o, coef_idx and coef_valid are stable and in_ready=0. Resume -> idx 2,3 follow.
- Back-to-back: two RAW words with coef_ready=1 and mode_i toggled to CBD for the second word -> 8 coefficients in 8 consecutive cycles. The second polynomial is decoded as CBD.
- Multi-word plus mid-reset: D=8, N=8 -> two words per polynomial, idx continues 4..7 from the second word. Pulsing rst at idx 5 -> valid drops asynchronously, and the next word restarts at idx 0.
